instr_decode_seq: RTL and testbench
===================================

// Module: instr_decode_seq
// PURPOSE
//  Instruction-register and decode sequencer for the 19-bit CPU. Accepts one 19-bit instruction per
//  valid/ready handshake and splits it into register-select fields. rd_sel drives the 3-to-8 decoder
//  select input; wb_en gates the decoder's one-hot output into the register-file write enables.
//  Sequences each instruction through DECODE, EXEC and WB, and flags illegal opcodes and execute timeouts.
// PARAMETERS
//  NUM_OPCODES   20  opcodes 0..NUM_OPCODES-1 are legal; opcode >= NUM_OPCODES is illegal (max 32)
//  EXEC_TIMEOUT  15  max cycles spent in EXEC waiting for exec_done; 0 = no timeout
//  CNT_W         16  width of retired_cnt
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  instr_valid  in   1      instr_in valid
//  instr_in     in   19     {opcode[18:14], rd[13:11], rs1[10:8], rs2[7:5], imm[4:0]}
//  instr_ready  out  1      sequencer can accept an instruction
//  exec_done    in   1      execute unit finished; sampled only in EXEC
//  opcode       out  5      latched opcode
//  rd_sel       out  3      latched destination; feeds decoder select
//  rs1_sel      out  3      latched source 1
//  rs2_sel      out  3      latched source 2
//  imm          out  5      latched immediate, zero-extended by consumers
//  exec_start   out  1      one-cycle pulse on the first EXEC cycle
//  wb_en        out  1      one-cycle register-write strobe (WB state)
//  busy         out  1      state != IDLE
//  illegal      out  1      one-cycle pulse: illegal opcode detected in DECODE
//  timeout      out  1      one-cycle pulse: EXEC_TIMEOUT expired
//  retired_cnt  out  CNT_W  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all field outputs 0; exec_start, wb_en, illegal, timeout,
//    busy = 0; instr_ready = 1 once rst_n=1; retired_cnt = 0; timeout counter = 0.
//  - FSM states: IDLE, DECODE, EXEC, WB. All outputs are registered; instr_ready = (state==IDLE).
//  - IDLE: on instr_valid && instr_ready, latch all fields at that edge and go to DECODE.
//    Fields hold their values until the next accept.
//  - DECODE (1 cycle): if opcode >= NUM_OPCODES, pulse illegal and go to IDLE (no exec, no wb).
//    Otherwise go to EXEC, with exec_start=1 for that first EXEC cycle only.
//  - EXEC: wait for exec_done.
//    - exec_done=1 and opcode[4]=0: go to WB.
//    - exec_done=1 and opcode[4]=1 (store/branch class, no writeback): retire and go to IDLE.
//    - exec_done high in the same cycle as exec_start is valid and counts.
//  - Timeout: the counter increments on each EXEC cycle without exec_done. When it reaches
//    EXEC_TIMEOUT, pulse timeout and go to IDLE with no wb and no retire. The counter clears on EXEC exit.
//  - WB (1 cycle): wb_en=1, retire, go to IDLE.
//  - Minimum latency, accept to wb_en: 3 cycles (DECODE, EXEC with done, WB). Back-to-back throughput:
//    one instruction per 4 cycles.
//  - exec_done outside EXEC is ignored. instr_valid outside IDLE is not accepted, and the upstream
//    holds instr_in.
//  - Reset mid-operation aborts immediately. There is no wb or exec_start pulse on reset release.
// CONFIGURATION
//  INSTR_COUNT_EN defined:
//    - retired_cnt increments by 1 on each retire (WB, or no-wb EXEC exit).
//    - Wraps from 2^CNT_W-1 to 0.
//    - Illegal and timed-out instructions are not counted.
//  INSTR_COUNT_EN undefined: retired_cnt is tied to 0 and no counter flops are inferred.
// TESTING
//  1 Reset, then send instr 19'h0EAE9 (op=3, rd=5, rs1=2, rs2=7, imm=9), exec_done 2 cycles after
//    exec_start -> rd_sel=5, rs1_sel=2, rs2_sel=7, imm=9, one wb_en pulse, retired_cnt=1 (macro on).
//  2 Opcode 5'd25 (>= NUM_OPCODES) -> illegal pulses 1 cycle after accept, no exec_start, no wb_en,
//    instr_ready=1 the next cycle.
//  3 Opcode 5'd17 (bit4=1), exec_done with exec_start -> no wb_en, back to IDLE, retired_cnt +1.
//  4 exec_done held 0 -> timeout pulses after 15 EXEC cycles, no wb_en, retired_cnt unchanged.
//  5 Drop rst_n during EXEC -> busy=0, instr_ready=1 after release, no wb_en, fields = 0.
//  6 Macro on, CNT_W=4: retire 17 instructions back to back -> retired_cnt=1 (wrap).
//    Macro off: retired_cnt=0 throughout.

Source files
------------

// File: rtl/instr_decode_seq_if.sv
// Handshake and decoded-field bundle between the instruction source and instr_decode_seq.
// master = instruction source / execute unit side, slave = the sequencer.
interface instr_decode_seq_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [18:0]      instr_in;
    logic             instr_ready;
    logic             exec_done;
    logic [4:0]       opcode;
    logic [2:0]       rd_sel;
    logic [2:0]       rs1_sel;
    logic [2:0]       rs2_sel;
    logic [4:0]       imm;
    logic             exec_start;
    logic             wb_en;
    logic             busy;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output instr_valid, instr_in, exec_done,
        input  instr_ready, opcode, rd_sel, rs1_sel, rs2_sel, imm,
        input  exec_start, wb_en, busy, illegal, timeout, retired_cnt
    );

    modport slave (
        input  instr_valid, instr_in, exec_done,
        output instr_ready, opcode, rd_sel, rs1_sel, rs2_sel, imm,
        output exec_start, wb_en, busy, illegal, timeout, retired_cnt
    );
endinterface

// File: rtl/instr_decode_seq.sv
// Instruction register and DECODE/EXEC/WB sequencer for the 19-bit CPU.
// Latches {opcode, rd, rs1, rs2, imm} on accept, flags illegal opcodes and execute
// timeouts, and strobes wb_en for one cycle to gate the rd_sel decoder into the
// register file. Optional feature macro: INSTR_COUNT_EN enables the retired-instruction
// counter; without it retired_cnt is tied to zero.
module instr_decode_seq #(
    parameter int NUM_OPCODES  = 20,
    parameter int EXEC_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_decode_seq_if.slave  bus
);

    localparam int TO_W = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      opcode_q, opcode_d;
    logic [2:0]      rd_sel_q, rd_sel_d;
    logic [2:0]      rs1_sel_q, rs1_sel_d;
    logic [2:0]      rs2_sel_q, rs2_sel_d;
    logic [4:0]      imm_q, imm_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            exec_start_q, exec_start_d;
    logic            wb_en_q, wb_en_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    // Next-state, field capture, timeout counting and registered output strobes.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        rd_sel_d     = rd_sel_q;
        rs1_sel_d    = rs1_sel_q;
        rs2_sel_d    = rs2_sel_q;
        imm_d        = imm_q;
        to_cnt_d     = to_cnt_q;
        exec_start_d = 1'b0;
        wb_en_d      = 1'b0;
        illegal_d    = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // instr_ready is exactly "state is IDLE", so valid alone completes the handshake
                if (bus.instr_valid) begin
                    opcode_d  = bus.instr_in[18:14];
                    rd_sel_d  = bus.instr_in[13:11];
                    rs1_sel_d = bus.instr_in[10:8];
                    rs2_sel_d = bus.instr_in[7:5];
                    imm_d     = bus.instr_in[4:0];
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (int'(opcode_q) >= NUM_OPCODES) begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    exec_start_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    to_cnt_d = '0;
                    // opcode[4] marks store/branch: retire straight from EXEC with no writeback
                    if (opcode_q[4]) begin
                        state_d = S_IDLE;
                    end else begin
                        wb_en_d = 1'b1;
                        state_d = S_WB;
                    end
                end else if (EXEC_TIMEOUT != 0) begin
                    // this is the EXEC_TIMEOUT-th cycle without done: abandon the instruction
                    if (to_cnt_q == TO_W'(EXEC_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        to_cnt_d  = '0;
                        state_d   = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State, latched fields and output strobes; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            rd_sel_q     <= '0;
            rs1_sel_q    <= '0;
            rs2_sel_q    <= '0;
            imm_q        <= '0;
            to_cnt_q     <= '0;
            exec_start_q <= 1'b0;
            wb_en_q      <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            rd_sel_q     <= rd_sel_d;
            rs1_sel_q    <= rs1_sel_d;
            rs2_sel_q    <= rs2_sel_d;
            imm_q        <= imm_d;
            to_cnt_q     <= to_cnt_d;
            exec_start_q <= exec_start_d;
            wb_en_q      <= wb_en_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.opcode      = opcode_q;
    assign bus.rd_sel      = rd_sel_q;
    assign bus.rs1_sel     = rs1_sel_q;
    assign bus.rs2_sel     = rs2_sel_q;
    assign bus.imm         = imm_q;
    assign bus.exec_start  = exec_start_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;
    assign bus.busy        = busy_q;

`ifdef INSTR_COUNT_EN
    logic             retire;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    // Retire on the WB cycle, or on an EXEC exit of the no-writeback class; wraps naturally.
    always_comb begin
        retire        = (state_q == S_WB) ||
                        ((state_q == S_EXEC) && bus.exec_done && opcode_q[4]);
        retired_cnt_d = retire ? retired_cnt_q + CNT_W'(1) : retired_cnt_q;
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign bus.retired_cnt = retired_cnt_q;
`else
    assign bus.retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_decode_seq.sv
// Self-checking bench for instr_decode_seq: directed vector table, reset/wrap sequences,
// and randomized instructions checked against a timeline model of the sequencer.
module tb_instr_decode_seq;

    localparam int NUM_OPC = 20;
    localparam int T       = 15;
    localparam int CW      = 4;
`ifdef INSTR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef enum int { C_WB, C_NOWB, C_ILL, C_TO } cls_e;

    typedef struct {
        logic [18:0] ins;
        int          d;
        cls_e        cls;
        logic [13:0] fields;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;

    instr_decode_seq_if #(.CNT_W(CW)) bus ();

    instr_decode_seq #(
        .NUM_OPCODES (NUM_OPC),
        .EXEC_TIMEOUT(T),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] fields_now();
        return {bus.rd_sel, bus.rs1_sel, bus.rs2_sel, bus.imm};
    endfunction

    function automatic logic [3:0] exp_retired();
        return CNT_ON ? 4'(exp_cnt % 16) : 4'd0;
    endfunction

    // What an instruction must do, given the planned exec_done delay d (EXEC cycles before done).
    function automatic cls_e classify(input logic [18:0] ins, input int d);
        if (int'(ins[18:14]) >= NUM_OPC) return C_ILL;
        if (d >= T)                      return C_TO;
        if (ins[18])                     return C_NOWB;
        return C_WB;
    endfunction

    // Called just after a negedge with the DUT idle. Samples s_n are taken at the negedge
    // following the n-th rising edge after the accept edge (n = 0 is the accept edge itself).
    task automatic run_instr(input logic [18:0] ins, input int d, input cls_e cls,
                             input logic [13:0] fields, input string tag);
        int endn;
        int exec_last;
        logic [5:0] exp_v;
        logic [5:0] act_v;
        case (cls)
            C_ILL:   endn = 1;
            C_TO:    endn = 1 + T;
            C_NOWB:  endn = 2 + d;
            default: endn = 3 + d;
        endcase
        exec_last = (cls == C_TO) ? T : 1 + d;
        bus.instr_valid = 1'b1;
        bus.instr_in    = ins;
        bus.exec_done   = 1'($urandom);
        for (int n = 0; n <= endn; n++) begin
            @(negedge clk);
            exp_v = {n < endn, n >= endn,
                     cls != C_ILL && n == 1,
                     cls == C_WB  && n == 2 + d,
                     cls == C_ILL && n == 1,
                     cls == C_TO  && n == 1 + T};
            act_v = {bus.busy, bus.instr_ready, bus.exec_start, bus.wb_en, bus.illegal, bus.timeout};
            check($sformatf("%s trace{busy,rdy,xs,wb,ill,to} s%0d", tag, n), 32'(act_v), 32'(exp_v));
            if (n == 0) begin
                check({tag, " opcode"}, 32'(bus.opcode), 32'(ins[18:14]));
                check({tag, " fields"}, 32'(fields_now()), 32'(fields));
            end
            if (n < endn) begin
                bus.instr_valid = 1'($urandom);
                if (cls != C_ILL && n >= 1 && n <= exec_last) bus.exec_done = (n - 1 == d);
                else                                           bus.exec_done = 1'($urandom);
            end else begin
                bus.instr_valid = 1'b0;
                bus.exec_done   = 1'b0;
            end
        end
        if (cls == C_WB || cls == C_NOWB) exp_cnt++;
        check({tag, " fields held"}, 32'(fields_now()), 32'(fields));
        check({tag, " retired_cnt"}, 32'(bus.retired_cnt), 32'(exp_retired()));
    endtask

    initial begin
        vec_t        tbl[$];
        logic [18:0] rins;
        int          rd;
        cls_e        rcls;

        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;

        tbl.push_back('{ins: 19'h0EAE9,                          d: 2,    cls: C_WB,   fields: {3'd5, 3'd2, 3'd7, 5'd9}});
        tbl.push_back('{ins: {5'd25, 3'd1, 3'd2, 3'd3, 5'd4},    d: 0,    cls: C_ILL,  fields: {3'd1, 3'd2, 3'd3, 5'd4}});
        tbl.push_back('{ins: {5'd17, 3'd6, 3'd5, 3'd4, 5'd31},   d: 0,    cls: C_NOWB, fields: {3'd6, 3'd5, 3'd4, 5'd31}});
        tbl.push_back('{ins: {5'd3,  3'd7, 3'd0, 3'd1, 5'd2},    d: 1000, cls: C_TO,   fields: {3'd7, 3'd0, 3'd1, 5'd2}});
        tbl.push_back('{ins: {5'd20, 3'd2, 3'd2, 3'd2, 5'd2},    d: 0,    cls: C_ILL,  fields: {3'd2, 3'd2, 3'd2, 5'd2}});
        tbl.push_back('{ins: {5'd19, 3'd3, 3'd4, 3'd5, 5'd6},    d: 14,   cls: C_NOWB, fields: {3'd3, 3'd4, 3'd5, 5'd6}});
        tbl.push_back('{ins: {5'd2,  3'd1, 3'd1, 3'd1, 5'd1},    d: 15,   cls: C_TO,   fields: {3'd1, 3'd1, 3'd1, 5'd1}});
        tbl.push_back('{ins: {5'd0,  3'd0, 3'd7, 3'd0, 5'd16},   d: 0,    cls: C_WB,   fields: {3'd0, 3'd7, 3'd0, 5'd16}});
        tbl.push_back('{ins: {5'd31, 3'd4, 3'd4, 3'd4, 5'd4},    d: 0,    cls: C_ILL,  fields: {3'd4, 3'd4, 3'd4, 5'd4}});
        tbl.push_back('{ins: {5'd16, 3'd2, 3'd6, 3'd3, 5'd7},    d: 5,    cls: C_NOWB, fields: {3'd2, 3'd6, 3'd3, 5'd7}});

        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
        bus.exec_done   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset strobes", 32'({bus.exec_start, bus.wb_en, bus.illegal, bus.timeout}), 32'd0);
        check("reset fields", 32'({bus.opcode, fields_now()}), 32'd0);
        check("reset retired_cnt", 32'(bus.retired_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", 32'(bus.instr_ready), 32'd1);

        foreach (tbl[i]) run_instr(tbl[i].ins, tbl[i].d, tbl[i].cls, tbl[i].fields, $sformatf("vec%0d", i));

        // Reset dropped while the instruction sits in EXEC.
        bus.instr_valid = 1'b1;
        bus.instr_in    = {5'd3, 3'd5, 3'd2, 3'd7, 5'd9};
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("rst-mid exec_start", 32'(bus.exec_start), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst-mid busy", 32'(bus.busy), 32'd0);
        check("rst-mid fields", 32'({bus.opcode, fields_now()}), 32'd0);
        check("rst-mid retired_cnt", 32'(bus.retired_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post-rst {busy,rdy,xs,wb,ill,to} c%0d", k),
                  32'({bus.busy, bus.instr_ready, bus.exec_start, bus.wb_en, bus.illegal, bus.timeout}),
                  32'b010000);
            check($sformatf("post-rst fields c%0d", k), 32'(fields_now()), 32'd0);
        end

        // 17 back-to-back retirements wrap a 4-bit counter to 1.
        for (int k = 0; k < 17; k++)
            run_instr({5'd1, 3'(k), 3'd1, 3'd2, 5'(k)}, 0, C_WB, {3'(k), 3'd1, 3'd2, 5'(k)},
                      $sformatf("wrap%0d", k));
        check("wrap retired_cnt", 32'(bus.retired_cnt), CNT_ON ? 32'd1 : 32'd0);

        // Randomized instructions, including delays straddling the timeout boundary.
        for (int k = 0; k < 40; k++) begin
            rins = 19'($urandom);
            case ($urandom_range(0, 5))
                0:       rd = 0;
                1:       rd = 1;
                2:       rd = T - 1;
                3:       rd = T;
                4:       rd = $urandom_range(2, 20);
                default: rd = $urandom_range(0, 3);
            endcase
            rcls = classify(rins, rd);
            run_instr(rins, rd, rcls, rins[13:0], $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
